// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// The state encoding is binary with IDLE at zero so a cleared register is idle.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic       PAR_EVEN     = 1'b0;
    localparam logic       PAR_ODD      = 1'b1;
    localparam logic [4:0] MIN_PRESCALE = 5'd8;

    function automatic logic [4:0] clamp_prescale(input logic [4:0] p);
        return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
    endfunction

    // Expected parity bit given the XOR-reduction of the data word.
    function automatic logic expected_parity(input logic data_xor, input logic typ);
        logic r;
        case (typ)
            PAR_EVEN: r = data_xor;
            PAR_ODD:  r = ~data_xor;
            default:  r = data_xor;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversampling edge counter and received-bit counter for the UART receiver.
// edge_end is combinational so the FSM can advance on the last edge of a bit.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    localparam int BW = $clog2(DATA_WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          busy,
    input  logic          abort,
    input  logic          bit_inc,
    input  logic [4:0]    prescale_l,
    output logic [4:0]    edge_count,
    output logic          edge_end,
    output logic [BW-1:0] bit_count
);

    assign edge_end = busy && (edge_count == (prescale_l - 5'd1));

    // Edge index within the current bit; held at zero outside the bit states.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_count <= 5'd0;
        end else if (!busy || abort || edge_end) begin
            edge_count <= 5'd0;
        end else begin
            edge_count <= edge_count + 5'd1;
        end
    end

    // Number of data bits evaluated in the current frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count <= '0;
        end else if (!busy) begin
            bit_count <= '0;
        end else if (bit_inc) begin
            bit_count <= bit_count + BW'(1);
        end else begin
            bit_count <= bit_count;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, frame FSM, data assembly and
// parity/stop checking with one-cycle result pulses.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  S_Data,
    input  logic [4:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  Sampled_bit,
    output logic [4:0]            edge_count,
    output logic                  edge_end,
    output logic                  S_EN,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_valid,
    output logic                  Par_err,
    output logic                  Stop_err
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    state_t                state_r, next_state_s, prev_state_r;
    logic                  bit_ready_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [4:0]            prescale_r;
    logic                  par_en_r, par_typ_r, par_flag_r;
    logic [BW-1:0]         bit_count_s;
    logic                  busy_s, start_det_s, glitch_s, data_eval_s, par_eval_s, last_bit_s;

    assign busy_s      = (state_r == START) || (state_r == DATA) ||
                         (state_r == PARITY) || (state_r == STOP);
    assign start_det_s = ((state_r == IDLE) || (state_r == DONE)) && !S_Data;
    // prev_state_r names the bit whose vote arrives with bit_ready_r.
    assign glitch_s    = bit_ready_r && (prev_state_r == START) && Sampled_bit;
    assign data_eval_s = bit_ready_r && (prev_state_r == DATA);
    assign par_eval_s  = bit_ready_r && (prev_state_r == PARITY);
    assign last_bit_s  = (bit_count_s == BW'(DATA_WIDTH - 1));

    edge_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_counter (
        .clk        (CLK),
        .reset      (Reset),
        .busy       (busy_s),
        .abort      (glitch_s),
        .bit_inc    (data_eval_s),
        .prescale_l (prescale_r),
        .edge_count (edge_count),
        .edge_end   (edge_end),
        .bit_count  (bit_count_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:   next_state_s = S_Data ? IDLE : START;
            START:  next_state_s = edge_end ? DATA : START;
            DATA: begin
                if (glitch_s) begin
                    next_state_s = IDLE;
                end else if (edge_end && last_bit_s) begin
                    next_state_s = par_en_r ? PARITY : STOP;
                end else begin
                    next_state_s = DATA;
                end
            end
            PARITY: next_state_s = edge_end ? STOP : PARITY;
            STOP:   next_state_s = edge_end ? DONE : STOP;
            DONE:   next_state_s = S_Data ? IDLE : START;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        S_EN = 1'b0;
        if (state_r != IDLE) begin
            S_EN = 1'b1;
        end else begin
            S_EN = 1'b0;
        end
    end

    // Bit timing, latched configuration, shift register and parity tracking.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            bit_ready_r  <= 1'b0;
            prev_state_r <= IDLE;
            prescale_r   <= 5'd0;
            par_en_r     <= 1'b0;
            par_typ_r    <= 1'b0;
            par_flag_r   <= 1'b0;
            shift_r      <= '0;
        end else begin
            bit_ready_r  <= edge_end;
            prev_state_r <= state_r;
            if (start_det_s) begin
                prescale_r <= clamp_prescale(Prescale);
                par_en_r   <= PAR_EN;
                par_typ_r  <= PAR_TYP;
                par_flag_r <= 1'b0;
            end else if (par_eval_s) begin
                par_flag_r <= (Sampled_bit != expected_parity(^shift_r, par_typ_r));
            end
            if (data_eval_s) begin
                shift_r <= {Sampled_bit, shift_r[DATA_WIDTH-1:1]};
            end
        end
    end

    // Result pulses registered on leaving DONE, where the stop vote is present.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stop_err   <= 1'b0;
            P_DATA     <= '0;
        end else if (state_r == DONE) begin
            Data_valid <= !par_flag_r && Sampled_bit;
            Par_err    <= par_flag_r;
            Stop_err   <= !Sampled_bit;
            if (!par_flag_r && Sampled_bit) begin
                P_DATA <= shift_r;
            end
        end else begin
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stop_err   <= 1'b0;
        end
    end

endmodule
